// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined integer adder/subtractor.
// Carry propagation is split into STAGES chunks of C = WIDTH/STAGES bits.
// Each stage sums one chunk and registers it, so each clock covers only one chunk.
// The last stage produces Data_out, carry, ovf and zero.
// Optional feature: define ADDSUB_SAT_EN to saturate on signed overflow when sat=1.
//
// Handshake:
//   A beat is accepted on a rising edge where in_valid && in_ready.
//   A result is consumed on a rising edge where out_valid && out_ready.
//   stall = out_valid && !out_ready freezes every stage register, valid bits included.
//   in_ready = !stall depends only on registered state and out_ready, never on in_valid.
module addsub_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Data_in1,
  input  logic [WIDTH-1:0] Data_in2,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Data_out,
  output logic             carry,
  output logic             ovf,
  output logic             zero
);

  localparam int C = WIDTH / STAGES;

  logic             stall;
  logic             accept;
  logic [WIDTH-1:0] b_eff;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;
  // Subtraction is A + ~B + 1; the +1 enters as the stage-0 carry-in.
  assign b_eff    = sub ? ~Data_in2 : Data_in2;

`ifndef ADDSUB_SAT_EN
  // Without saturation support the sat input has no function.
  logic unused_sat;
  assign unused_sat = sat;
`endif

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    // RW: operand bits not yet summed when the beat enters this stage.
    // SW: sum bits known once this stage has added its chunk.
    localparam int RW = WIDTH - i * C;
    localparam int SW = (i + 1) * C;

    logic [RW-1:0] a_in;
    logic [RW-1:0] b_in;
    logic          c_in;
    logic          v_in;
    logic [C:0]    chunk;
    logic [SW-1:0] s_out;
`ifdef ADDSUB_SAT_EN
    logic          sat_in;
`endif

    if (i == 0) begin : g_head
      assign a_in  = Data_in1;
      assign b_in  = b_eff;
      assign c_in  = sub;
      assign v_in  = accept;
      assign s_out = chunk[C-1:0];
`ifdef ADDSUB_SAT_EN
      assign sat_in = sat;
`endif
    end else begin : g_body
      assign a_in  = g_stage[i-1].g_reg.a_r;
      assign b_in  = g_stage[i-1].g_reg.b_r;
      assign c_in  = g_stage[i-1].g_reg.c_r;
      assign v_in  = g_stage[i-1].g_reg.v_r;
      assign s_out = {chunk[C-1:0], g_stage[i-1].g_reg.s_r};
`ifdef ADDSUB_SAT_EN
      assign sat_in = g_stage[i-1].g_reg.sat_r;
`endif
    end

    // This stage's chunk: the low C bits of the remaining operands, plus the incoming carry.
    assign chunk = {1'b0, a_in[C-1:0]} + {1'b0, b_in[C-1:0]} + {{C{1'b0}}, c_in};

    if (i < STAGES - 1) begin : g_reg
      logic [RW-C-1:0] a_r;
      logic [RW-C-1:0] b_r;
      logic [SW-1:0]   s_r;
      logic            c_r;
      logic            v_r;
`ifdef ADDSUB_SAT_EN
      logic            sat_r;
`endif

      // Intermediate stage register: advance the beat, or hold it on stall.
      always_ff @(posedge clk) begin
        if (rst) begin
          a_r <= '0;
          b_r <= '0;
          s_r <= '0;
          c_r <= 1'b0;
          v_r <= 1'b0;
`ifdef ADDSUB_SAT_EN
          sat_r <= 1'b0;
`endif
        end else if (!stall) begin
          a_r <= a_in[RW-1:C];
          b_r <= b_in[RW-1:C];
          s_r <= s_out;
          c_r <= chunk[C];
          v_r <= v_in;
`ifdef ADDSUB_SAT_EN
          sat_r <= sat_in;
`endif
        end
      end
    end else begin : g_out
      logic             raw_ovf;
      logic [WIDTH-1:0] res;

      // Signed overflow: both operands have the same sign, and the sum's sign differs from it.
      assign raw_ovf = (a_in[C-1] == b_in[C-1]) && (s_out[WIDTH-1] != a_in[C-1]);

`ifdef ADDSUB_SAT_EN
      // Clamp toward the sign of A. Only Data_out and zero see the clamp.
      always_comb begin
        res = s_out;
        if (sat_in && raw_ovf) begin
          res = a_in[C-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
      end
`else
      assign res = s_out;
`endif

      // Output register: publish the completed result and its flags, or hold on stall.
      always_ff @(posedge clk) begin
        if (rst) begin
          out_valid <= 1'b0;
          Data_out  <= '0;
          carry     <= 1'b0;
          ovf       <= 1'b0;
          zero      <= 1'b0;
        end else if (!stall) begin
          out_valid <= v_in;
          Data_out  <= res;
          carry     <= chunk[C];
          ovf       <= raw_ovf;
          zero      <= (res == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe: scoreboard bench for addsub_pipe (WIDTH=32, STAGES=2).
// Define ADDSUB_SAT_EN for both the bench and the design to exercise saturation.
module tb_addsub_pipe;
  localparam int WIDTH  = 32;
  localparam int STAGES = 2;
  localparam int EW     = WIDTH + 3;  // {zero, ovf, carry, data}
`ifdef ADDSUB_SAT_EN
  localparam bit SAT_ON = 1'b1;
`else
  localparam bit SAT_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] Data_in1;
  logic [WIDTH-1:0] Data_in2;
  logic             sub;
  logic             sat;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Data_out;
  logic             carry;
  logic             ovf;
  logic             zero;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  logic [EW-1:0] exp_q[$];
  int            acc_q[$];
  bit            lat_q[$];

  bit            hold_prev = 1'b0;
  logic [EW:0]   hold_val;
  bit            rnd_done  = 1'b0;

  addsub_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .Data_in1 (Data_in1),
    .Data_in2 (Data_in2),
    .sub      (sub),
    .sat      (sat),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Data_out (Data_out),
    .carry    (carry),
    .ovf      (ovf),
    .zero     (zero)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: plain signed/unsigned arithmetic on the operand values
  function automatic logic [EW-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                          input logic s, input logic st);
    longint sa, sb, ua, ub, exact, max_s, min_s;
    logic [WIDTH-1:0] d;
    logic c, o, z;
    max_s = (longint'(1) <<< (WIDTH - 1)) - 1;
    min_s = -(longint'(1) <<< (WIDTH - 1));
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    exact = s ? (sa - sb) : (sa + sb);
    c = s ? (ua >= ub) : ((ua + ub) > longint'({WIDTH{1'b1}}));
    o = (exact > max_s) || (exact < min_s);
    d = WIDTH'(exact);
    if (SAT_ON && st && o) d = (exact > 0) ? WIDTH'(max_s) : WIDTH'(min_s);
    z = (d == '0);
    return {z, o, c, d};
  endfunction

  function automatic logic [WIDTH-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b0, {(WIDTH-1){1'b1}}};
      3:       return {1'b1, {(WIDTH-1){1'b0}}};
      4:       return 32'h0000FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Driver: present a beat until accepted, then record its expected result
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s,
                      input logic st, input logic [EW-1:0] e, input bit lat);
    bit done  = 1'b0;
    int tries = 0;
    Data_in1 = a;
    Data_in2 = b;
    sub      = s;
    sat      = st;
    in_valid = 1'b1;
    while (!done && tries < 100) begin
      @(negedge clk);
      if (in_ready && !rst) begin
        exp_q.push_back(e);
        acc_q.push_back(cyc);
        lat_q.push_back(lat);
        done = 1'b1;
      end
      tries++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=no_accept required=accept");
    end
  endtask

  task automatic send_rand(input bit lat);
    logic [WIDTH-1:0] a, b;
    logic s, st;
    a  = rand_operand();
    b  = rand_operand();
    s  = 1'($urandom_range(0, 1));
    st = 1'($urandom_range(0, 1));
    send(a, b, s, st, model(a, b, s, st), lat);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: scoreboard pop/compare on each output handshake, plus output hold under stall
  always @(negedge clk) begin : monitor
    logic [EW-1:0] e;
    int a;
    bit l;
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) check("stall_hold", {out_valid, zero, ovf, carry, Data_out}, hold_val);
      if (out_valid && !out_ready) begin
        hold_prev = 1'b1;
        hold_val  = {out_valid, zero, ovf, carry, Data_out};
      end else begin
        hold_prev = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat actual=0x%0h required=none", Data_out);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          l = lat_q.pop_front();
          check("data", Data_out, e[WIDTH-1:0]);
          check("flags_zoc", {zero, ovf, carry}, e[EW-1:WIDTH]);
          if (l) check("latency", cyc - a, STAGES);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  // Stimulus sequence
  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    Data_in1  = '0;
    Data_in2  = '0;
    sub       = 1'b0;
    sat       = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_data", Data_out, 0);
    check("rst_flags", {zero, ovf, carry}, 0);
    @(posedge clk);
    #1;

    // Directed corner cases, out_ready held high
    send(32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, {3'b010, 32'h80000000}, 1'b1);
    send(32'h7FFFFFFF, 32'h1, 1'b0, 1'b1,
         SAT_ON ? {3'b010, 32'h7FFFFFFF} : {3'b010, 32'h80000000}, 1'b1);
    send(32'd5, 32'd5, 1'b1, 1'b0, {3'b101, 32'h0}, 1'b1);
    send(32'd0, 32'd1, 1'b1, 1'b0, {3'b000, 32'hFFFFFFFF}, 1'b1);
    send(32'h0000FFFF, 32'h1, 1'b0, 1'b0, {3'b000, 32'h00010000}, 1'b1);
    send(32'h80000000, 32'h1, 1'b1, 1'b1,
         SAT_ON ? {3'b011, 32'h80000000} : {3'b011, 32'h7FFFFFFF}, 1'b1);
    send(32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, {3'b101, 32'h0}, 1'b1);
    idle(4);

    // Streaming: 8 back-to-back beats
    repeat (8) send_rand(1'b1);
    idle(4);

    // Stall with a full pipeline for 3 cycles
    out_ready = 1'b0;
    fork
      begin
        repeat (4) send_rand(1'b0);
      end
      begin : stall_ctl
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
          @(negedge clk);
          n++;
        end
        if (!out_valid) begin
          checks++;
          errors++;
          $display("FAIL stall_fill actual=out_valid_low required=out_valid_high");
        end
        for (int k = 0; k < 3; k++) begin
          check("stall_in_ready", in_ready, 0);
          check("stall_out_valid", out_valid, 1);
          if (k < 2) @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    idle(5);

    // Random traffic with random back-pressure
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send_rand(1'b0);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    idle(6);
    check("drain_random", exp_q.size(), 0);

    // Reset with two beats in flight; a beat offered during reset must be dropped
    send_rand(1'b0);
    send_rand(1'b0);
    exp_q.delete();
    acc_q.delete();
    lat_q.delete();
    rst      = 1'b1;
    in_valid = 1'b1;
    Data_in1 = $urandom;
    Data_in2 = $urandom;
    sub      = 1'b0;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_data", Data_out, 0);
    check("midrst_flags", {zero, ovf, carry}, 0);
    check("midrst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    idle(6);

    // Recovery after reset
    send(32'h12345678, 32'h11111111, 1'b1, 1'b0, model(32'h12345678, 32'h11111111, 1'b0 + 1'b1, 1'b0), 1'b1);
    idle(5);
    check("drain_final", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
